eth_rcc_mode_seq: RTL and testbench
===================================

// Module: eth_rcc_mode_seq
// PURPOSE
//  ETH-side sequencer that drives the RCC kernel-clock mode inputs (eth_rcc_fes, eth_rcc_epis_2).
//  On a software mode request it runs these steps in order:
//    1. Holds the MAC datapath and drops the kernel-clock request.
//    2. Applies the new speed/interface select and waits for the RCC clock switch to settle.
//    3. Re-requests the clocks and confirms that the returned MII RX kernel clock is toggling.
//  It sits in the ETH wrapper, on the other side of the RCC ETH kernel clock controller.
// PARAMETERS
//  QUIESCE_CYC 16   cycles the hold is asserted before the select change (>=1)
//  SETTLE_CYC  64   cycles waited after the select change, clock request still low (>=1)
//  MON_WIN     256  maximum cycles spent in CHECK looking for RX clock edges (>=MIN_EDGES)
//  MIN_EDGES   2    synchronized rising edges needed to declare the clock alive (>=1)
// PORTS
//  clk            in  1 bus clock; the only clock of the block
//  rst_n          in  1 asynchronous active-low reset
//  cfg_req        in  1 mode request, sampled in IDLE only
//  cfg_fes        in  1 requested speed: 1=100M (div2), 0=10M (div20)
//  cfg_epis_2     in  1 requested interface: 1=RMII, 0=MII
//  err_clr        in  1 clears the sticky cfg_err flag
//  rx_clk_mon     in  1 rcc_eth_mii_rx_clk, asynchronous; sampled as data
//  eth_rcc_fes    out 1 registered speed select to RCC
//  eth_rcc_epis_2 out 1 registered interface select to RCC
//  eth_clk_req    out 1 kernel-clock request to RCC (feeds the eth1rx/eth1tx enables)
//  mac_txrx_hold  out 1 freezes the MAC TX/RX datapath
//  cfg_busy       out 1 high whenever the FSM is not in IDLE
//  cfg_ack        out 1 one-cycle pulse when a request completes
//  cfg_err        out 1 sticky flag: the last sequence saw no RX clock
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately, also mid-sequence):
//   - state=IDLE; fes=0, epis_2=0, eth_clk_req=1, hold=0, busy=0, ack=0, err=0; all counters=0.
//  All outputs are registers or decodes of the state register; no combinational path from inputs.
//  FSM states: IDLE, QUIESCE, SWITCH, SETTLE, CHECK, DONE.
//   IDLE: on cfg_req=1, latch cfg_fes/cfg_epis_2.
//     - Latched values equal current outputs -> DONE (no hold, no clock drop).
//     - Otherwise -> QUIESCE.
//   QUIESCE: hold=1, eth_clk_req=0; stays exactly QUIESCE_CYC cycles, then -> SWITCH.
//   SWITCH: one cycle; eth_rcc_fes/epis_2 load the latched values (visible this cycle); -> SETTLE.
//   SETTLE: hold=1, eth_clk_req=0; stays exactly SETTLE_CYC cycles, then -> CHECK.
//   CHECK: eth_clk_req=1, hold=1; the window counter starts at 0.
//     - Edge count reaches MIN_EDGES -> DONE.
//     - Window counter reaches MON_WIN with too few edges -> DONE, and cfg_err is set.
//   DONE: one cycle; cfg_ack=1, hold=0, eth_clk_req=1; -> IDLE. busy=1 in every state except IDLE.
//  Edge detection:
//   - rx_clk_mon passes through a 2-flop synchronizer plus one history flop.
//   - A rising edge is s2 & ~s3.
//   - The edge count runs only in CHECK and saturates at MIN_EDGES.
//  Requests and errors:
//   - cfg_req while busy is ignored; it is neither queued nor acknowledged.
//   - cfg_err stays high until err_clr. If set and clear occur in the same cycle, set wins.
//   - A new request does not clear cfg_err.
//  Counter widths are $clog2(max param + 1); counters never wrap.
//  Latency, with request sampled at cycle 0:
//   - QUIESCE occupies 1..Q; SWITCH is Q+1; SETTLE occupies Q+2..Q+S+1; CHECK starts at Q+S+2.
//   - On timeout, DONE is at Q+S+2+MON_WIN.
// TESTING  (Q=4, S=8, MON_WIN=32, MIN_EDGES=2, rx_clk_mon period 4 clk unless stated)
//  1. Release reset -> fes=0, epis_2=0, eth_clk_req=1, hold=0, busy=0, ack=0, err=0.
//  2. cfg_req with fes=1, epis_2=0 at cycle 0:
//     - hold=1 from cycle 1; eth_clk_req=0 over cycles 1..13; fes=1 from cycle 5.
//     - eth_clk_req=1 from cycle 14; one ack pulse within about 10 cycles of that; err=0.
//  3. Request repeating the current mode -> DONE at cycle 1, ack at cycle 1; hold and clk_req never change.
//  4. rx_clk_mon held at 0 with epis_2 changing -> ack at cycle 46, err=1 and stays 1.
//     err_clr=1 for one cycle -> err=0 the next cycle.
//  5. cfg_req pulsed in SETTLE -> ignored, exactly one ack.
//     rst_n low at cycle 9 -> all outputs at reset values immediately, state IDLE.
//  6. err_clr=1 in the same cycle the timeout sets the error -> err=1.

Source files
------------

// File: rtl/eth_rcc_mode_seq.sv
// Sequencer that safely switches the RCC ETH kernel-clock mode (speed/interface select):
// hold MAC, drop clock request, change select, settle, re-request and confirm the RX clock.
module eth_rcc_mode_seq #(
  parameter int QUIESCE_CYC = 16,
  parameter int SETTLE_CYC  = 64,
  parameter int MON_WIN     = 256,
  parameter int MIN_EDGES   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_req,
  input  logic cfg_fes,
  input  logic cfg_epis_2,
  input  logic err_clr,
  input  logic rx_clk_mon,
  output logic eth_rcc_fes,
  output logic eth_rcc_epis_2,
  output logic eth_clk_req,
  output logic mac_txrx_hold,
  output logic cfg_busy,
  output logic cfg_ack,
  output logic cfg_err
);

  localparam int MAX_QS  = (QUIESCE_CYC > SETTLE_CYC) ? QUIESCE_CYC : SETTLE_CYC;
  localparam int MAX_QSW = (MAX_QS > MON_WIN) ? MAX_QS : MON_WIN;
  localparam int MAX_P   = (MAX_QSW > MIN_EDGES) ? MAX_QSW : MIN_EDGES;
  localparam int CW      = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_SWITCH,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] edge_cnt, edge_nxt, edge_inc;
  logic          lat_fes, lat_epis;
  logic          sync1, sync2, sync3;
  logic          rise;
  logic          load_sel;
  logic          err_set;

  // Two flops resolve metastability on the foreign RX clock; the third keeps history.
  assign rise = sync2 & ~sync3;
  assign edge_inc = (edge_cnt == CW'(MIN_EDGES)) ? edge_cnt : edge_cnt + CW'(rise);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = '0;
    edge_nxt  = '0;
    load_sel  = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_req) begin
          if (cfg_fes == eth_rcc_fes && cfg_epis_2 == eth_rcc_epis_2) state_nxt = S_DONE;
          else                                                        state_nxt = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        if (cnt == CW'(QUIESCE_CYC - 1)) begin
          state_nxt = S_SWITCH;
          load_sel  = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_SWITCH: state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (cnt == CW'(SETTLE_CYC - 1)) state_nxt = S_CHECK;
        else                            cnt_nxt   = cnt + CW'(1);
      end
      S_CHECK: begin
        edge_nxt = edge_inc;
        cnt_nxt  = cnt + CW'(1);
        // A sufficient edge count wins over a window expiring in the same cycle.
        if (edge_inc == CW'(MIN_EDGES)) begin
          state_nxt = S_DONE;
        end else if (cnt == CW'(MON_WIN - 1)) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      edge_cnt       <= '0;
      lat_fes        <= 1'b0;
      lat_epis       <= 1'b0;
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      sync3          <= 1'b0;
      eth_rcc_fes    <= 1'b0;
      eth_rcc_epis_2 <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      edge_cnt <= edge_nxt;
      sync1    <= rx_clk_mon;
      sync2    <= sync1;
      sync3    <= sync2;
      if (state == S_IDLE && cfg_req) begin
        lat_fes  <= cfg_fes;
        lat_epis <= cfg_epis_2;
      end
      if (load_sel) begin
        eth_rcc_fes    <= lat_fes;
        eth_rcc_epis_2 <= lat_epis;
      end
      if (err_set)      cfg_err <= 1'b1;
      else if (err_clr) cfg_err <= 1'b0;
    end
  end

  // Remaining outputs are pure decodes of the state register.
  assign mac_txrx_hold = (state == S_QUIESCE) || (state == S_SWITCH) ||
                         (state == S_SETTLE)  || (state == S_CHECK);
  assign eth_clk_req   = !((state == S_QUIESCE) || (state == S_SWITCH) || (state == S_SETTLE));
  assign cfg_busy      = (state != S_IDLE);
  assign cfg_ack       = (state == S_DONE);

endmodule

// File: tb/tb_eth_rcc_mode_seq.sv
// Self-checking bench for eth_rcc_mode_seq: directed tables, multi-cycle corner sequences and
// randomized traffic compared every cycle against a timeline-based reference model.
module tb_eth_rcc_mode_seq;

  localparam int Q = 4;
  localparam int S = 8;
  localparam int W = 32;
  localparam int E = 2;

  logic clk = 1'b0;
  logic rst_n, cfg_req, cfg_fes, cfg_epis_2, err_clr, rx_clk_mon;
  logic eth_rcc_fes, eth_rcc_epis_2, eth_clk_req, mac_txrx_hold, cfg_busy, cfg_ack, cfg_err;

  eth_rcc_mode_seq #(.QUIESCE_CYC(Q), .SETTLE_CYC(S), .MON_WIN(W), .MIN_EDGES(E)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_fes(cfg_fes), .cfg_epis_2(cfg_epis_2),
    .err_clr(err_clr), .rx_clk_mon(rx_clk_mon), .eth_rcc_fes(eth_rcc_fes),
    .eth_rcc_epis_2(eth_rcc_epis_2), .eth_clk_req(eth_clk_req), .mac_txrx_hold(mac_txrx_hold),
    .cfg_busy(cfg_busy), .cfg_ack(cfg_ack), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rx_mode  = 0;

  // Reference model: a request is a timeline of offsets from the sampling cycle.
  bit m_fes, m_epis, m_err, m_act, m_same, l_fes, l_epis;
  int m_k, m_done_k, m_edges;
  bit p1, p2, p3;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fes = 0; m_epis = 0; m_err = 0; m_act = 0; m_same = 0; l_fes = 0; l_epis = 0;
    m_k = 0; m_done_k = 0; m_edges = 0; p1 = 0; p2 = 0; p3 = 0;
  endtask

  task automatic model_edge();
    bit rise;
    bit set_err;
    rise    = p2 & ~p3;
    set_err = 0;
    if (m_act) begin
      if (m_k == m_done_k) begin
        m_act = 0;
      end else begin
        if (!m_same && m_k == Q) begin
          m_fes  = l_fes;
          m_epis = l_epis;
        end
        if (!m_same && m_k >= Q + S + 2) begin
          if (rise && m_edges < E) m_edges++;
          if (m_edges >= E) begin
            m_done_k = m_k + 1;
          end else if (m_k == Q + S + 1 + W) begin
            m_done_k = m_k + 1;
            set_err  = 1;
          end
        end
        m_k++;
      end
    end else if (cfg_req) begin
      m_act    = 1;
      m_k      = 1;
      l_fes    = cfg_fes;
      l_epis   = cfg_epis_2;
      m_same   = (cfg_fes == m_fes) && (cfg_epis_2 == m_epis);
      m_done_k = m_same ? 1 : 0;
      m_edges  = 0;
    end
    if (set_err)      m_err = 1;
    else if (err_clr) m_err = 0;
    p3 = p2; p2 = p1; p1 = rx_clk_mon;
  endtask

  task automatic compare_all();
    bit in_seq;
    in_seq = m_act && !m_same && (m_k != m_done_k);
    check("busy",    cfg_busy,       m_act);
    check("ack",     cfg_ack,        m_act && (m_k == m_done_k));
    check("hold",    mac_txrx_hold,  in_seq);
    check("clk_req", eth_clk_req,    !(in_seq && m_k <= Q + S + 1));
    check("fes",     eth_rcc_fes,    m_fes);
    check("epis_2",  eth_rcc_epis_2, m_epis);
    check("err",     cfg_err,        m_err);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    case (rx_mode)
      0:       rx_clk_mon = 1'b0;
      1:       rx_clk_mon = 1'b1;
      2:       rx_clk_mon = cyc[1];
      3:       rx_clk_mon = cyc[0];
      default: rx_clk_mon = 1'($urandom_range(1));
    endcase
    compare_all();
  endtask

  task automatic request(input bit fes, input bit epis);
    cfg_req = 1; cfg_fes = fes; cfg_epis_2 = epis;
    tick();
    cfg_req = 0;
  endtask

  typedef struct {
    int at;
    bit hold;
    bit clk_req;
    bit fes;
    bit busy;
    bit ack;
  } vec_t;

  vec_t tv[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int off;
    int acks;

    tv[0] = '{at: 0,  hold: 0, clk_req: 1, fes: 0, busy: 0, ack: 0};
    tv[1] = '{at: 1,  hold: 1, clk_req: 0, fes: 0, busy: 1, ack: 0};
    tv[2] = '{at: 4,  hold: 1, clk_req: 0, fes: 0, busy: 1, ack: 0};
    tv[3] = '{at: 5,  hold: 1, clk_req: 0, fes: 1, busy: 1, ack: 0};
    tv[4] = '{at: 6,  hold: 1, clk_req: 0, fes: 1, busy: 1, ack: 0};
    tv[5] = '{at: 13, hold: 1, clk_req: 0, fes: 1, busy: 1, ack: 0};
    tv[6] = '{at: 14, hold: 1, clk_req: 1, fes: 1, busy: 1, ack: 0};

    rst_n = 1; cfg_req = 0; cfg_fes = 0; cfg_epis_2 = 0; err_clr = 0; rx_clk_mon = 0;
    model_reset();
    #2 rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;

    // Reset values.
    check("rst_fes", eth_rcc_fes, 1'b0);
    check("rst_epis", eth_rcc_epis_2, 1'b0);
    check("rst_clk_req", eth_clk_req, 1'b1);
    check("rst_hold", mac_txrx_hold, 1'b0);
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_ack", cfg_ack, 1'b0);
    check("rst_err", cfg_err, 1'b0);

    // Speed change with a live RX clock: table of timeline checkpoints.
    rx_mode = 2;
    cfg_req = 1; cfg_fes = 1; cfg_epis_2 = 0;
    off = 0;
    for (int i = 0; i < 7; i++) begin
      while (off < tv[i].at) begin
        tick();
        cfg_req = 0;
        off++;
      end
      check($sformatf("t2_hold@%0d", tv[i].at), mac_txrx_hold, tv[i].hold);
      check($sformatf("t2_clk_req@%0d", tv[i].at), eth_clk_req, tv[i].clk_req);
      check($sformatf("t2_fes@%0d", tv[i].at), eth_rcc_fes, tv[i].fes);
      check($sformatf("t2_busy@%0d", tv[i].at), cfg_busy, tv[i].busy);
      check($sformatf("t2_ack@%0d", tv[i].at), cfg_ack, tv[i].ack);
    end
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cfg_ack === 1'b1) acks++;
    end
    check("t2_one_ack", acks == 1, 1'b1);
    check("t2_err", cfg_err, 1'b0);

    // Request repeating the current mode completes immediately.
    request(1, 0);
    check("t3_ack", cfg_ack, 1'b1);
    check("t3_hold", mac_txrx_hold, 1'b0);
    check("t3_clk_req", eth_clk_req, 1'b1);
    tick();
    check("t3_idle", cfg_busy, 1'b0);

    // Dead RX clock: timeout at offset Q+S+2+W, sticky error, then clear.
    rx_mode = 0;
    request(1, 1);
    for (int i = 0; i < 44; i++) tick();
    check("t4_no_ack_45", cfg_ack, 1'b0);
    tick();
    check("t4_ack_46", cfg_ack, 1'b1);
    check("t4_err_46", cfg_err, 1'b1);
    tick();
    check("t4_err_sticky", cfg_err, 1'b1);
    err_clr = 1;
    tick();
    err_clr = 0;
    check("t4_err_clr", cfg_err, 1'b0);

    // Clear and timeout-set in the same cycle: set wins.
    request(1, 0);
    for (int i = 0; i < 44; i++) tick();
    err_clr = 1;
    tick();
    err_clr = 0;
    check("t6_ack", cfg_ack, 1'b1);
    check("t6_set_wins", cfg_err, 1'b1);
    tick();

    // Request during SETTLE is ignored; exactly one ack, first mode applied.
    rx_mode = 2;
    request(0, 0);
    for (int i = 1; i < 8; i++) tick();
    cfg_req = 1; cfg_fes = 1; cfg_epis_2 = 1;
    tick();
    cfg_req = 0;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cfg_ack === 1'b1) acks++;
    end
    check("t5_one_ack", acks == 1, 1'b1);
    check("t5_fes", eth_rcc_fes, 1'b0);
    check("t5_epis", eth_rcc_epis_2, 1'b0);

    // Asynchronous reset mid-sequence.
    request(1, 1);
    for (int i = 1; i < 9; i++) tick();
    #3 rst_n = 0;
    #1;
    model_reset();
    check("t5r_fes", eth_rcc_fes, 1'b0);
    check("t5r_epis", eth_rcc_epis_2, 1'b0);
    check("t5r_clk_req", eth_clk_req, 1'b1);
    check("t5r_hold", mac_txrx_hold, 1'b0);
    check("t5r_busy", cfg_busy, 1'b0);
    check("t5r_ack", cfg_ack, 1'b0);
    check("t5r_err", cfg_err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rx_mode = int'($urandom_range(4));
      cfg_req    = ($urandom_range(7) == 0);
      cfg_fes    = 1'($urandom_range(1));
      cfg_epis_2 = 1'($urandom_range(1));
      err_clr    = ($urandom_range(15) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
